// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width math, parameter legality, reset values.
// No logic; constant functions and localparams only.
// Backpressure: n/a.
package sync_fifo_pkg;

  localparam bit RST_ERR  = 1'b0;
  localparam bit RST_FULL = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int thresh, input int depth);
    return (thresh >= 0) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port FIFO storage; read port registered, or combinational when SYNC_FIFO_FWFT_EN.
// Latency: 1 cycle registered read, 0 cycles in fall-through mode.
// Backpressure: none; caller gates we/re with full/empty.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with count, almost thresholds and error pulses; SYNC_FIFO_FWFT_EN selects fall-through read.
// Latency: read data 1 cycle after pop (0 in fall-through); flags 1 cycle after the accepted op.
// Backpressure: writes dropped while full, reads ignored while empty, each flagged by a one-cycle err pulse.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int PTR_WIDTH     = clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] AF_LVL  = CW'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] AE_LVL  = CW'(AEMPTY_THRESH);
  localparam logic [PTR_WIDTH:0] PTR_INC = {{PTR_WIDTH{1'b0}}, 1'b1};

  if (DEPTH < 4 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_ctrl: DEPTH must be a power of two and at least 4");
  end
  if (PTR_WIDTH != clog2(DEPTH)) begin : g_bad_ptr
    $error("sync_fifo_ctrl: PTR_WIDTH must equal log2(DEPTH)");
  end
  if (!thresh_ok(AFULL_THRESH, DEPTH) || !thresh_ok(AEMPTY_THRESH, DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_ctrl: thresholds must lie within 0..DEPTH");
  end

  logic [PTR_WIDTH:0]    wptr, rptr;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_ok = w_en & ~full;
  assign rd_ok = r_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      wr_err <= RST_ERR;
      rd_err <= RST_ERR;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_INC;
      if (rd_ok) rptr <= rptr + PTR_INC;
      wr_err <= w_en & full;
      rd_err <= r_en & empty;
    end
  end

  // Extra wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                 (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr[PTR_WIDTH-1:0]),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rptr[PTR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head slot is stale once drained, so the last popped word is held instead.
  logic [DATA_WIDTH-1:0] last_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_pop <= '0;
    else if (rd_ok) last_pop <= ram_rdata;
  end

  assign data_out = empty ? last_pop : ram_rdata;
`else
  assign data_out = ram_rdata;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl at DEPTH=8, DATA_WIDTH=8 (thresholds 6 / 2).
// Set SYNC_FIFO_FWFT_EN for the fall-through build.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       wr_err, rd_err;

  int total = 0;
  int bad   = 0;

  sync_fifo_ctrl #(
    .DATA_WIDTH (8),
    .DEPTH      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .wr_err       (wr_err),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given request, outputs sampled 1 ns after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    w_en    = w;
    data_in = d;
    r_en    = r;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  // Pop and check the popped word where each read mode presents it.
  task automatic pop(input string tag, input logic [7:0] exp, input logic w, input logic [7:0] d);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, 32'(data_out), 32'(exp));
    step(w, d, 1'b1);
`else
    step(w, d, 1'b1);
    chk(tag, 32'(data_out), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_errs", 32'({wr_err, rd_err}), 0);
    chk("rst_dout", 32'(data_out), 0);
    rst = 1'b0;

    // Fill to full, watching thresholds.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_full", 32'(full), 32'(i == 8));
      chk("fill_afull", 32'(almost_full), 32'(i >= 6));
      chk("fill_aempty", 32'(almost_empty), 32'(i <= 2));
    end
    step(1'b1, 8'h09, 1'b0);
    chk("ovf_wr_err", 32'(wr_err), 1);
    chk("ovf_count", 32'(count), 8);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_wr_err_clr", 32'(wr_err), 0);

    for (int i = 1; i <= 8; i++) begin
      pop("drain_data", 8'(i), 1'b0, 8'h00);
      chk("drain_count", 32'(count), 32'(8 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_rd_err", 32'(rd_err), 1);
    chk("udf_dout_hold", 32'(data_out), 8'h08);
    step(1'b0, 8'h00, 1'b0);
    chk("udf_rd_err_clr", 32'(rd_err), 0);

    // 20 writes with 3 in flight: pointers wrap past the 8-entry boundary.
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h10 + k), 1'b0);
    for (int k = 0; k < 17; k++) begin
      pop("wrap_data", 8'(8'h10 + k), 1'b1, 8'(8'h13 + k));
      chk("wrap_count", 32'(count), 3);
    end
    for (int k = 17; k < 20; k++) pop("wrap_tail", 8'(8'h10 + k), 1'b0, 8'h00);
    chk("wrap_empty", 32'(empty), 1);

    // Simultaneous request while full.
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h40 + k), 1'b0);
    chk("sim_full_pre", 32'(full), 1);
    pop("sim_full_data", 8'h40, 1'b1, 8'h77);
    chk("sim_full_wr_err", 32'(wr_err), 1);
    chk("sim_full_count", 32'(count), 7);
    for (int k = 1; k < 8; k++) pop("sim_full_drain", 8'(8'h40 + k), 1'b0, 8'h00);
    chk("sim_full_no_wr", 32'(empty), 1);

    // Simultaneous request while empty.
    step(1'b1, 8'h55, 1'b1);
    chk("sim_empty_rd_err", 32'(rd_err), 1);
    chk("sim_empty_count", 32'(count), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("sim_empty_dout", 32'(data_out), 8'h55);
`else
    chk("sim_empty_dout", 32'(data_out), 8'h47);
`endif
    pop("sim_empty_pop", 8'h55, 1'b0, 8'h00);

    // Asynchronous reset with data queued.
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h60 + k), 1'b0);
    chk("pre_rst_count", 32'(count), 5);
    rst = 1'b1;
    #2;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_dout", 32'(data_out), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'hA5, 1'b0);
    pop("post_rst_data", 8'hA5, 1'b0, 8'h00);
    chk("post_rst_empty", 32'(empty), 1);

`ifdef SYNC_FIFO_FWFT_EN
    step(1'b1, 8'h3C, 1'b0);
    chk("fwft_empty", 32'(empty), 0);
    chk("fwft_dout", 32'(data_out), 8'h3C);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", 32'(empty), 1);
    chk("fwft_hold", 32'(data_out), 8'h3C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
